// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
interface clk_div_prog_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_ratio;
  logic             clk_out;
  logic             tick;
  logic             active;

  modport master (output en, output div_ratio, input clk_out, input tick, input active);
  modport slave  (input en, input div_ratio, output clk_out, output tick, output active);
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: clk_out = clk_in / N, N in 2..2^CNT_W-1,
// ratio and enable changes applied only at period boundaries.
module clk_div_prog #(
  parameter int unsigned CNT_W  = 8,
  parameter bit          ODD_50 = 1'b1
) (
  input  logic          clk_in,
  input  logic          reset,
  clk_div_prog_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] n_act, n_act_nx;
  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] high_len;
  logic             q, q_nx;
  logic             q_neg;
  logic             tick_r, tick_nx;
  logic             load;
  logic             at_end;
  logic             odd_sel;

  assign n_eff    = (bus.div_ratio < CNT_W'(2)) ? CNT_W'(2) : bus.div_ratio;
  assign high_len = (n_act >> 1) + CNT_W'((n_act[0] && !ODD_50) ? 1 : 0);
  assign at_end   = (cnt == n_act - CNT_W'(1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    n_act_nx = n_act;
    q_nx     = q;
    tick_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        q_nx   = 1'b0;
        if (bus.en) load = 1'b1;
      end
      RUN: begin
        if (!at_end) begin
          cnt_nx = cnt + CNT_W'(1);
          q_nx   = (cnt + CNT_W'(1)) < high_len;
        end else if (bus.en) begin
          load = 1'b1;
        end else begin
          state_nx = IDLE;
          q_nx     = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A load (from IDLE or at a boundary) always starts a fresh period high.
    if (load) begin
      n_act_nx = n_eff;
      cnt_nx   = '0;
      q_nx     = 1'b1;
      tick_nx  = 1'b1;
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      n_act  <= CNT_W'(2);
      q      <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      n_act  <= n_act_nx;
      q      <= q_nx;
      tick_r <= tick_nx;
    end
  end

  // Half-cycle extension for odd ratios; q_neg is always 0 when the mux
  // select changes (load point), so the output cannot glitch.
  generate
    if (ODD_50) begin : g_neg
      always_ff @(negedge clk_in or posedge reset) begin
        if (reset) q_neg <= 1'b0;
        else       q_neg <= q;
      end
    end else begin : g_no_neg
      assign q_neg = 1'b0;
    end
  endgenerate

  assign odd_sel     = ODD_50 && n_act[0];
  assign bus.clk_out = odd_sel ? (q | q_neg) : q;
  assign bus.tick    = tick_r;
  assign bus.active  = (state == RUN);

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized bench for clk_div_prog (ODD_50=1 and ODD_50=0 instances) against
// a half-cycle waveform model derived from period position and ratio.
module tb_clk_div_prog;

  logic       clk;
  logic       reset;
  logic       en;
  logic [7:0] ratio;

  int unsigned n_checks;
  int unsigned n_pass;

  // Reference model: whether running, position within the period, period length.
  bit          running;
  int unsigned pos;
  int unsigned n_cur;

  clk_div_prog_if #(.CNT_W(8)) bus_a ();
  clk_div_prog_if #(.CNT_W(8)) bus_b ();

  assign bus_a.en        = en;
  assign bus_a.div_ratio = ratio;
  assign bus_b.en        = en;
  assign bus_b.div_ratio = ratio;

  clk_div_prog #(.CNT_W(8), .ODD_50(1'b1)) dut_a (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus_a.slave)
  );

  clk_div_prog #(.CNT_W(8), .ODD_50(1'b0)) dut_b (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  function automatic int unsigned clamp(input int unsigned r);
    return (r < 2) ? 2 : r;
  endfunction

  // Number of high half-cycles in one period of 2N half-cycles.
  function automatic int unsigned high_halves(input int unsigned n, input bit odd50);
    if (odd50) return n;
    return ((n + 1) / 2) * 2;
  endfunction

  function automatic bit exp_out(input bit odd50, input int unsigned half);
    return running && ((2 * pos + half) < high_halves(n_cur, odd50));
  endfunction

  function automatic void model_edge();
    if (reset) return;
    if (!running) begin
      if (en) begin
        running = 1'b1;
        pos     = 0;
        n_cur   = clamp(ratio);
      end
    end else if (pos == n_cur - 1) begin
      if (en) begin
        pos   = 0;
        n_cur = clamp(ratio);
      end else begin
        running = 1'b0;
        pos     = 0;
      end
    end else begin
      pos++;
    end
  endfunction

  // One clk cycle: model steps on posedge, outputs checked in both halves.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("clk_out_odd50_hi", bus_a.clk_out, exp_out(1'b1, 0));
    check_eq("clk_out_even_hi",  bus_b.clk_out, exp_out(1'b0, 0));
    check_eq("tick_a",   bus_a.tick,   running && pos == 0);
    check_eq("tick_b",   bus_b.tick,   running && pos == 0);
    check_eq("active_a", bus_a.active, running);
    check_eq("active_b", bus_b.active, running);
    @(negedge clk);
    #1;
    check_eq("clk_out_odd50_lo", bus_a.clk_out, exp_out(1'b1, 1));
    check_eq("clk_out_even_lo",  bus_b.clk_out, exp_out(1'b0, 1));
  endtask

  task automatic run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) step();
  endtask

  task automatic run_to_pos(input int unsigned p);
    for (int unsigned i = 0; i < 300 && !(running && pos == p); i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_clk_out_a"}, bus_a.clk_out, 0);
    check_eq({tag, "_clk_out_b"}, bus_b.clk_out, 0);
    check_eq({tag, "_tick_a"},    bus_a.tick,    0);
    check_eq({tag, "_tick_b"},    bus_b.tick,    0);
    check_eq({tag, "_active_a"},  bus_a.active,  0);
    check_eq({tag, "_active_b"},  bus_b.active,  0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    running  = 1'b0;
    pos      = 0;
    n_cur    = 2;
    reset    = 1'b1;
    en       = 1'b0;
    ratio    = 8'd4;
    #12;
    check_all_zero("reset");
    run(2);
    reset = 1'b0;

    // N=4 from idle, then ratio change mid-period to 6.
    en = 1'b1;
    run(9);
    run_to_pos(1);
    ratio = 8'd6;
    run(14);

    // Odd ratio: 50% on dut_a, 3/2 on dut_b.
    ratio = 8'd5;
    run(16);

    // N=3, drop en at cnt=0, then reassert.
    ratio = 8'd3;
    run(4);
    run_to_pos(0);
    en = 1'b0;
    run(6);
    en = 1'b1;
    run(7);

    // Ratios below 2 clamp to 2.
    ratio = 8'd0;
    run(8);
    ratio = 8'd1;
    run(8);

    // Async reset during the high phase of an N=8 period.
    ratio = 8'd8;
    run(3);
    run_to_pos(0);
    run_to_pos(2);
    reset   = 1'b1;
    running = 1'b0;
    pos     = 0;
    #1;
    check_all_zero("async_reset");
    run(2);
    reset = 1'b0;
    run(20);

    // Random ratio/en traffic; occasional maximum ratio.
    for (int unsigned i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) ratio = 8'($urandom_range(0, 13));
      if ($urandom_range(0, 299) == 0) ratio = 8'd255;
      if ($urandom_range(0, 19) == 0) en = ~en;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
